// File: rtl/dds_ctrl_pkg.sv
// Shared types and default constants for the DDS key-tuning controller.
// The op encoding is captured once per press and replayed unchanged on every auto-repeat.
package dds_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        HOLD,
        REPEAT,
        WAIT_REL
    } state_t;

    typedef enum logic [2:0] {
        FTW_UP,
        FTW_DN,
        DUTY_UP,
        DUTY_DN,
        PH_UP,
        PH_DN,
        RESTORE
    } op_t;

    localparam logic [31:0] DEF_FTW_RESET   = 32'd42950;
    localparam logic [31:0] DEF_FTW_MAX     = 32'h7FFF_FFFF;
    localparam logic [31:0] DEF_STEP_FINE   = 32'd43;
    localparam logic [31:0] DEF_STEP_MID    = 32'd42950;
    localparam logic [31:0] DEF_STEP_COARSE = 32'd42949673;
    localparam logic [31:0] DEF_PHASE_STEP  = 32'h4000_0000;
    localparam logic [31:0] DEF_DUTY_STEP   = 32'h4000_0000;
    localparam logic [31:0] DEF_DUTY_RESET  = 32'h8000_0000;
    localparam int unsigned DEF_HOLD_CYCLES   = 25_000_000;
    localparam int unsigned DEF_REPEAT_CYCLES = 5_000_000;

    // Index of the single low key in an active-low one-hot pattern.
    function automatic logic [1:0] key_index(input logic [2:0] k);
        logic [1:0] idx;
        idx = 2'd2;
        if (!k[0]) idx = 2'd0;
        else if (!k[1]) idx = 2'd1;
        return idx;
    endfunction

    function automatic op_t decode_op(input logic [1:0] key, input logic freq, input logic up);
        op_t op;
        op = RESTORE;
        if (freq) op = up ? FTW_UP : FTW_DN;
        else if (key == 2'd0) op = up ? DUTY_UP : DUTY_DN;
        else if (key == 2'd1) op = up ? PH_UP : PH_DN;
        return op;
    endfunction

endpackage

// File: rtl/dds_tune_ctrl_timer.sv
// Hold / auto-repeat down-counter: loaded on each applied op, expires when it
// reaches zero while enabled, so a load of N-1 gives an N-cycle period.
module dds_repeat_timer
    import dds_ctrl_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic load,
    input  logic sel_repeat,
    input  logic en,
    output logic expire
);

    localparam logic [31:0] HOLD_RELOAD   = 32'(HOLD_CYCLES - 1);
    localparam logic [31:0] REPEAT_RELOAD = 32'(REPEAT_CYCLES - 1);

    logic [31:0] count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= sel_repeat ? REPEAT_RELOAD : HOLD_RELOAD;
        end else if (en && count != 32'd0) begin
            count <= count - 32'd1;
        end
    end

    assign expire = en && (count == 32'd0);

endmodule

// File: rtl/dds_tune_ctrl.sv
// Key-press sequencer for the DDS FTW, phase offset and PWM duty registers,
// with press detection, hold-to-repeat and single-key arbitration.
module dds_tune_ctrl
    import dds_ctrl_pkg::*;
#(
    parameter logic [31:0] FTW_RESET     = DEF_FTW_RESET,
    parameter logic [31:0] FTW_MAX       = DEF_FTW_MAX,
    parameter logic [31:0] STEP_FINE     = DEF_STEP_FINE,
    parameter logic [31:0] STEP_MID      = DEF_STEP_MID,
    parameter logic [31:0] STEP_COARSE   = DEF_STEP_COARSE,
    parameter logic [31:0] PHASE_STEP    = DEF_PHASE_STEP,
    parameter logic [31:0] DUTY_STEP     = DEF_DUTY_STEP,
    parameter logic [31:0] DUTY_RESET    = DEF_DUTY_RESET,
    parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        freq_phase_sel,
    input  logic        up_down_sel,
    input  logic [2:0]  key_n,
    output logic [31:0] ftw,
    output logic [31:0] phase_ofs,
    output logic [31:0] pwm_duty,
    output logic        param_update,
    output logic        busy
);

    state_t      state, state_n;
    op_t         op_q;
    logic [31:0] step_q;
    logic [2:0]  k_q, pat_q;
    logic        rep_q;
    logic        one_hot;
    logic        capture, do_apply, set_rep;
    logic        tmr_clear, tmr_load, tmr_en, expire;
    logic [32:0] ftw_sum;

    // Not reset: a key held through reset must still be seen as held.
    always_ff @(posedge clk) begin
        k_q <= key_n;
    end

    assign one_hot = (k_q == 3'b110) || (k_q == 3'b101) || (k_q == 3'b011);
    assign ftw_sum = {1'b0, ftw} + {1'b0, step_q};

    dds_repeat_timer #(
        .HOLD_CYCLES   (HOLD_CYCLES),
        .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .clear      (tmr_clear),
        .load       (tmr_load),
        .sel_repeat (rep_q),
        .en         (tmr_en),
        .expire     (expire)
    );

    always_ff @(posedge clk) begin
        if (!reset) state <= WAIT_REL;
        else        state <= state_n;
    end

    always_comb begin
        state_n   = state;
        capture   = 1'b0;
        do_apply  = 1'b0;
        set_rep   = 1'b0;
        tmr_clear = 1'b0;
        tmr_load  = 1'b0;
        tmr_en    = 1'b0;
        case (state)
            IDLE: begin
                tmr_clear = 1'b1;
                if (k_q == 3'b111) begin
                    state_n = IDLE;
                end else if (one_hot) begin
                    capture = 1'b1;
                    state_n = APPLY;
                end else begin
                    state_n = WAIT_REL;
                end
            end
            APPLY: begin
                do_apply = 1'b1;
                tmr_load = 1'b1;
                state_n  = rep_q ? REPEAT : HOLD;
            end
            HOLD, REPEAT: begin
                if (k_q != pat_q) begin
                    state_n = WAIT_REL;
                end else begin
                    tmr_en = 1'b1;
                    if (expire) begin
                        set_rep = (state == HOLD);
                        state_n = APPLY;
                    end
                end
            end
            WAIT_REL: begin
                if (k_q == 3'b111) state_n = IDLE;
            end
            default: state_n = WAIT_REL;
        endcase
    end

    // The op is frozen at press time; mode selects are ignored until release.
    always_ff @(posedge clk) begin
        if (!reset) begin
            op_q   <= FTW_UP;
            step_q <= '0;
            pat_q  <= 3'b111;
            rep_q  <= 1'b0;
        end else begin
            if (capture) begin
                op_q  <= decode_op(key_index(k_q), freq_phase_sel, up_down_sel);
                pat_q <= k_q;
                rep_q <= 1'b0;
                case (key_index(k_q))
                    2'd0:    step_q <= STEP_FINE;
                    2'd1:    step_q <= STEP_MID;
                    default: step_q <= STEP_COARSE;
                endcase
            end else if (set_rep) begin
                rep_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ftw          <= FTW_RESET;
            phase_ofs    <= '0;
            pwm_duty     <= DUTY_RESET;
            param_update <= 1'b0;
            busy         <= 1'b1;
        end else begin
            param_update <= do_apply;
            busy         <= (state_n != IDLE);
            if (do_apply) begin
                case (op_q)
                    FTW_UP:  ftw <= (ftw_sum > {1'b0, FTW_MAX}) ? FTW_MAX : ftw_sum[31:0];
                    FTW_DN:  ftw <= (ftw < step_q) ? 32'd0 : ftw - step_q;
                    DUTY_UP: pwm_duty <= pwm_duty + DUTY_STEP;
                    DUTY_DN: pwm_duty <= pwm_duty - DUTY_STEP;
                    PH_UP:   phase_ofs <= phase_ofs + PHASE_STEP;
                    PH_DN:   phase_ofs <= phase_ofs - PHASE_STEP;
                    RESTORE: begin
                        phase_ofs <= '0;
                        pwm_duty  <= DUTY_RESET;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dds_tune_ctrl.sv
// Testbench for dds_tune_ctrl: directed scenarios plus random single presses,
// every param_update pulse checked against an expected-value queue.
module tb_dds_tune_ctrl;

    localparam int          HOLD   = 10;
    localparam int          REP    = 4;
    localparam logic [31:0] F_RST  = 32'd42950;
    localparam logic [31:0] F_MAX  = 32'h7FFF_FFFF;
    localparam logic [31:0] D_RST  = 32'h8000_0000;
    localparam logic [31:0] Q_STEP = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        freq_phase_sel = 1'b1;
    logic        up_down_sel = 1'b1;
    logic [2:0]  key_n = 3'b111;
    logic [31:0] ftw, phase_ofs, pwm_duty;
    logic        param_update, busy;

    int checks = 0;
    int failures = 0;

    logic [95:0] exp_q[$];
    logic [31:0] m_ftw, m_ph, m_duty;
    logic [31:0] steps [3];

    dds_tune_ctrl #(
        .HOLD_CYCLES   (HOLD),
        .REPEAT_CYCLES (REP)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .freq_phase_sel (freq_phase_sel),
        .up_down_sel    (up_down_sel),
        .key_n          (key_n),
        .ftw            (ftw),
        .phase_ofs      (phase_ofs),
        .pwm_duty       (pwm_duty),
        .param_update   (param_update),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: the register effect of one applied key op.
    task automatic model_apply(input int key, input bit freq, input bit up);
        longint s;
        if (freq) begin
            if (up) begin
                s = longint'(m_ftw) + longint'(steps[key]);
                m_ftw = (s > longint'(F_MAX)) ? F_MAX : 32'(s);
            end else begin
                m_ftw = (m_ftw < steps[key]) ? 32'd0 : m_ftw - steps[key];
            end
        end else if (key == 0) begin
            m_duty = up ? m_duty + Q_STEP : m_duty - Q_STEP;
        end else if (key == 1) begin
            m_ph = up ? m_ph + Q_STEP : m_ph - Q_STEP;
        end else begin
            m_ph   = 32'd0;
            m_duty = D_RST;
        end
        exp_q.push_back({m_ftw, m_ph, m_duty});
    endtask

    task automatic model_reset();
        m_ftw  = F_RST;
        m_ph   = 32'd0;
        m_duty = D_RST;
    endtask

    // Updates produced by a key held h cycles: first op enters APPLY two edges
    // after the press, the next after HOLD more cycles, then every REP cycles.
    function automatic int n_updates(input int h);
        int e, n;
        e = h + 1;
        n = 0;
        if (e >= 2) n = 1;
        if (e >= 3 + HOLD) n += (e - (3 + HOLD)) / (REP + 1) + 1;
        return n;
    endfunction

    always @(negedge clk) begin
        if (param_update === 1'b1) begin
            logic [95:0] e;
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_update observed=pulse expected=none ftw=%h", ftw);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("upd_ftw", ftw, e[95:64]);
                check("upd_phase", phase_ofs, e[63:32]);
                check("upd_duty", pwm_duty, e[31:0]);
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        model_reset();
    endtask

    task automatic wait_idle(input string tag);
        int w = 0;
        repeat (3) @(posedge clk);
        while (busy !== 1'b0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        check(tag, {31'd0, busy}, 32'd0);
        check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic press(input int key, input bit freq, input bit up, input int h);
        logic [2:0] pat;
        pat = 3'b111;
        pat[key] = 1'b0;
        for (int i = 0; i < n_updates(h); i++) model_apply(key, freq, up);
        @(posedge clk);
        #1 freq_phase_sel = freq; up_down_sel = up; key_n = pat;
        repeat (h) @(posedge clk);
        #1 key_n = 3'b111;
        wait_idle("press_idle");
    endtask

    initial begin
        steps[0] = 32'd43;
        steps[1] = 32'd42950;
        steps[2] = 32'd42949673;
        do_reset();
        #1;
        check("rst_ftw", ftw, F_RST);
        check("rst_phase", phase_ofs, 32'd0);
        check("rst_duty", pwm_duty, D_RST);
        check("rst_upd", {31'd0, param_update}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd1);
        wait_idle("rst_idle");

        // Single fine-up press, with the 3-cycle latency checked edge by edge.
        model_apply(0, 1'b1, 1'b1);
        @(posedge clk);
        #1 freq_phase_sel = 1'b1; up_down_sel = 1'b1; key_n = 3'b110;
        repeat (2) @(posedge clk);
        #1 check("lat2_upd", {31'd0, param_update}, 32'd0);
        @(posedge clk);
        #1 check("lat3_upd", {31'd0, param_update}, 32'd1);
        check("lat3_ftw", ftw, 32'd42993);
        key_n = 3'b111;
        wait_idle("t1_idle");

        // Drive to saturation, back off two coarse steps, then hold into the clamp.
        press(2, 1'b1, 1'b1, 400);
        check("sat_ftw", ftw, F_MAX);
        press(2, 1'b1, 1'b0, 3);
        press(2, 1'b1, 1'b0, 3);
        check("n_updates_24", 32'(n_updates(24)), 32'd4);
        press(2, 1'b1, 1'b1, 24);
        check("clamp_ftw", ftw, F_MAX);

        // Phase down five times from reset wraps through zero.
        do_reset();
        for (int i = 0; i < 5; i++) press(1, 1'b0, 1'b0, 3);
        check("ph_wrap", phase_ofs, 32'hC000_0000);

        // Duty up twice wraps, restore brings phase and duty back.
        press(0, 1'b0, 1'b1, 2);
        check("duty_c", pwm_duty, 32'hC000_0000);
        press(0, 1'b0, 1'b1, 2);
        check("duty_wrap", pwm_duty, 32'h0000_0000);
        press(2, 1'b0, 1'b0, 2);
        check("restore_duty", pwm_duty, D_RST);
        check("restore_phase", phase_ofs, 32'd0);
        check("restore_ftw", ftw, F_RST);

        // Random short presses across all keys and modes.
        for (int i = 0; i < 30; i++) begin
            press(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), int'($urandom_range(1, 8)));
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        check("rand_ftw", ftw, m_ftw);
        check("rand_phase", phase_ofs, m_ph);
        check("rand_duty", pwm_duty, m_duty);

        // Two keys down: locked out until full release.
        @(posedge clk);
        #1 key_n = 3'b100;
        repeat (6) @(posedge clk);
        #1 check("multi_busy", {31'd0, busy}, 32'd1);
        key_n = 3'b111;
        wait_idle("multi_idle");
        press(1, 1'b0, 1'b1, 3);

        // Reset pulsed while auto-repeating: back to reset values, key ignored.
        for (int i = 0; i < 3; i++) model_apply(0, 1'b1, 1'b1);
        @(posedge clk);
        #1 freq_phase_sel = 1'b1; up_down_sel = 1'b1; key_n = 3'b110;
        repeat (20) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        model_reset();
        check("mid_rst_ftw", ftw, F_RST);
        check("mid_rst_phase", phase_ofs, 32'd0);
        check("mid_rst_duty", pwm_duty, D_RST);
        check("mid_rst_upd", {31'd0, param_update}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd1);
        repeat (20) @(posedge clk);
        #1 check("held_busy", {31'd0, busy}, 32'd1);
        check("held_ftw", ftw, F_RST);
        key_n = 3'b111;
        wait_idle("rst_rel_idle");
        press(0, 1'b1, 1'b1, 3);
        check("after_rst_ftw", ftw, 32'd42993);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
